// File: rtl/amba3_axi2apb_bridge_pkg.sv
// Shared AMBA3 types and burst helpers for the AXI3-to-APB3 bridge.
package amba3_axi2apb_bridge_pkg;

  localparam int unsigned AXI_LEN_W   = 4;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RBEAT  = 3'd4,
    BRESP  = 3'd5
  } axi2apb_state_t;

  // Address of the next beat; reserved burst and illegal wrap lengths behave as INCR.
  function automatic logic [63:0] next_burst_addr(input logic [63:0]            addr,
                                                  input logic [AXI_LEN_W-1:0]   len,
                                                  input logic [AXI_SIZE_W-1:0]  size,
                                                  input logic [AXI_BURST_W-1:0] burst);
    logic [63:0] incr;
    logic [63:0] wmask;
    incr  = addr + (64'd1 << size);
    wmask = ((64'(len) + 64'd1) << size) - 64'd1;
    if (burst == BURST_FIXED) return addr;
    if (burst == BURST_WRAP && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
      return (addr & ~wmask) | (incr & wmask);
    return incr;
  endfunction

  // Most severe of two responses: DECERR > SLVERR > OKAY.
  function automatic resp_type_t resp_max(input resp_type_t a, input resp_type_t b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/amba3_apb_decoder.sv
// Combinational APB slave decoder; lowest-index matching window wins.
module amba3_apb_decoder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned IDX_W      = 2,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx_c,
  output logic                  hit_c
);

  always_comb begin
    idx_c = '0;
    hit_c = 1'b0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        idx_c = IDX_W'(i);
        hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amba3_axi2apb_bridge.sv
// AXI3 slave to APB3 master bridge, one transaction at a time, bursts split per beat.
// Optional PREADY timeout built when AMBA3_AXI2APB_TIMEOUT_EN is defined.
module amba3_axi2apb_bridge
  import amba3_axi2apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK =
    {NUM_SLAVES{ADDR_WIDTH'(32'hFFFF_F000)}},
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             aclk,
  input  logic                             areset_n,
  input  logic [ID_WIDTH-1:0]              awid,
  input  logic [ADDR_WIDTH-1:0]            awaddr,
  input  logic [3:0]                       awlen,
  input  logic [2:0]                       awsize,
  input  logic [1:0]                       awburst,
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [ID_WIDTH-1:0]              wid,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic                             wlast,
  input  logic                             wvalid,
  output logic                             wready,
  output logic [ID_WIDTH-1:0]              bid,
  output logic [1:0]                       bresp,
  output logic                             bvalid,
  input  logic                             bready,
  input  logic [ID_WIDTH-1:0]              arid,
  input  logic [ADDR_WIDTH-1:0]            araddr,
  input  logic [3:0]                       arlen,
  input  logic [2:0]                       arsize,
  input  logic [1:0]                       arburst,
  input  logic                             arvalid,
  output logic                             arready,
  output logic [ID_WIDTH-1:0]              rid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  output logic                             rlast,
  output logic                             rvalid,
  input  logic                             rready,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic                             penable,
  output logic [NUM_SLAVES-1:0]            psel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int unsigned IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned SIZE_MAX = $clog2(DATA_WIDTH / 8);

  axi2apb_state_t         state;
  logic                   rd_first;
  logic                   wr_q;
  logic [ID_WIDTH-1:0]    id_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [AXI_LEN_W-1:0]   len_q;
  logic [AXI_SIZE_W-1:0]  size_q;
  logic [AXI_BURST_W-1:0] burst_q;
  logic [AXI_LEN_W-1:0]   beat_q;
  resp_type_t             acc_q;
  resp_type_t             err_resp_q;
  logic                   err_q;
  logic                   wlast_q;
  logic [IDX_W-1:0]       idx_q;

  logic [ADDR_WIDTH-1:0]  dec_addr;
  logic [AXI_SIZE_W-1:0]  dec_size;
  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_hit;
  logic                   go_setup_c;
  logic                   pready_sel;
  logic                   pslverr_sel;
  logic [DATA_WIDTH-1:0]  prdata_sel;
  logic                   timeout_hit;
  logic                   beat_done;
  resp_type_t             beat_resp_c;
  resp_type_t             wr_resp_c;
  logic [DATA_WIDTH-1:0]  beat_rdata;
  logic [ADDR_WIDTH-1:0]  next_addr;
  logic                   unused_ok;

  // The first beat of a read decodes the AR address directly while still in IDLE.
  assign dec_addr   = (state == IDLE) ? araddr : addr_q;
  assign dec_size   = (state == IDLE) ? arsize : size_q;
  assign go_setup_c = (state == IDLE  && arready && arvalid) ||
                      (state == WDATA && wvalid) ||
                      (state == RBEAT && rready && !rlast);

  assign pready_sel  = pready[idx_q];
  assign pslverr_sel = pslverr[idx_q];
  assign prdata_sel  = prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign next_addr   = ADDR_WIDTH'(next_burst_addr(64'(addr_q), len_q, size_q, burst_q));
  assign unused_ok   = ^{wstrb, wid};

  amba3_apb_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .addr  (dec_addr),
    .idx_c (dec_idx),
    .hit_c (dec_hit)
  );

`ifdef AMBA3_AXI2APB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge aclk) begin
    if (!areset_n || state != ACCESS) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign timeout_hit = (state == ACCESS) && !pready_sel &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Beat completion: decode/size error in SETUP, or PREADY/timeout in ACCESS.
  always_comb begin
    beat_done   = 1'b0;
    beat_resp_c = RESP_OKAY;
    beat_rdata  = '0;
    if (state == SETUP && err_q) begin
      beat_done   = 1'b1;
      beat_resp_c = err_resp_q;
    end else if (state == ACCESS && (pready_sel || timeout_hit)) begin
      beat_done = 1'b1;
      if (pready_sel) begin
        beat_rdata  = prdata_sel;
        beat_resp_c = pslverr_sel ? RESP_SLVERR : RESP_OKAY;
      end else begin
        beat_resp_c = RESP_SLVERR;
      end
    end
  end

  always_comb begin
    wr_resp_c = resp_max(acc_q, beat_resp_c);
    if (wlast_q != (beat_q == len_q)) wr_resp_c = RESP_SLVERR;
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state      <= IDLE;
      rd_first   <= 1'b1;
      wr_q       <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      acc_q      <= RESP_OKAY;
      err_resp_q <= RESP_OKAY;
      err_q      <= 1'b0;
      wlast_q    <= 1'b0;
      idx_q      <= '0;
      awready    <= 1'b0;
      arready    <= 1'b0;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
      bid        <= '0;
      bresp      <= '0;
      rvalid     <= 1'b0;
      rid        <= '0;
      rdata      <= '0;
      rresp      <= '0;
      rlast      <= 1'b0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      penable    <= 1'b0;
      psel       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arready) begin
            if (arvalid) begin
              arready  <= 1'b0;
              rd_first <= 1'b0;
              wr_q     <= 1'b0;
              id_q     <= arid;
              addr_q   <= araddr;
              len_q    <= arlen;
              size_q   <= arsize;
              burst_q  <= arburst;
              beat_q   <= '0;
              acc_q    <= RESP_OKAY;
              state    <= SETUP;
            end
          end else if (awready) begin
            if (awvalid) begin
              awready  <= 1'b0;
              rd_first <= 1'b1;
              wr_q     <= 1'b1;
              id_q     <= awid;
              addr_q   <= awaddr;
              len_q    <= awlen;
              size_q   <= awsize;
              burst_q  <= awburst;
              beat_q   <= '0;
              acc_q    <= RESP_OKAY;
              wready   <= 1'b1;
              state    <= WDATA;
            end
          end else if (arvalid && (!awvalid || rd_first)) begin
            arready <= 1'b1;
          end else if (awvalid) begin
            awready <= 1'b1;
          end
        end
        WDATA: begin
          if (wvalid) begin
            wready  <= 1'b0;
            wlast_q <= wlast;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (!err_q) begin
            penable <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: ;
        RBEAT: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= rlast ? IDLE : SETUP;
          end
        end
        BRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (beat_done) begin
        psel    <= '0;
        penable <= 1'b0;
        addr_q  <= next_addr;
        beat_q  <= beat_q + AXI_LEN_W'(1);
        if (!wr_q) begin
          rvalid <= 1'b1;
          rid    <= id_q;
          rdata  <= beat_rdata;
          rresp  <= beat_resp_c;
          rlast  <= (beat_q == len_q);
          state  <= RBEAT;
        end else begin
          acc_q <= wr_resp_c;
          if (beat_q == len_q) begin
            bvalid <= 1'b1;
            bid    <= id_q;
            bresp  <= wr_resp_c;
            state  <= BRESP;
          end else begin
            wready <= 1'b1;
            state  <= WDATA;
          end
        end
      end

      // Setup phase of the next beat; errors are resolved here so no PSEL is issued.
      if (go_setup_c) begin
        paddr  <= dec_addr;
        pwrite <= (state == WDATA);
        idx_q  <= dec_idx;
        if (state == WDATA) pwdata <= wdata;
        if (dec_hit && dec_size <= AXI_SIZE_W'(SIZE_MAX)) begin
          psel  <= NUM_SLAVES'(1) << dec_idx;
          err_q <= 1'b0;
        end else begin
          err_q      <= 1'b1;
          err_resp_q <= dec_hit ? RESP_SLVERR : RESP_DECERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_amba3_axi2apb_bridge.sv
// Scoreboard bench for amba3_axi2apb_bridge: directed bursts, errors, arbitration, timeout.
module tb_amba3_axi2apb_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned NS = 4;
  localparam logic [NS-1:0][AW-1:0] BASE =
    {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
  localparam logic [NS-1:0][AW-1:0] MASK = {NS{32'hFFFF_F000}};

  logic aclk, areset_n;
  logic [IW-1:0] awid, wid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr, paddr;
  logic [3:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready, pwrite, penable;
  logic [DW-1:0] wdata, rdata, pwdata;
  logic [DW/8-1:0] wstrb;
  logic [NS-1:0] psel, pready, pslverr;
  logic [NS*DW-1:0] prdata;

  logic pready_en, err_en;
  logic [AW-1:0] err_addr;

  typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wd; int slv; } apb_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] d; logic [1:0] resp; logic last; } r_t;
  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_t;

  apb_t apb_q[$];
  r_t   r_q[$];
  b_t   b_q[$];
  int   ord_q[$];
  int   r_times[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int sel_cnt = 0;
  int pen_cnt = 0;

  amba3_axi2apb_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .NUM_SLAVES(NS),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .penable(penable), .psel(psel),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // APB slave models: slave i returns {i, paddr[27:0]}.
  always_comb begin
    for (int i = 0; i < NS; i++) prdata[i*DW +: DW] = {4'(i), paddr[27:0]};
  end
  assign pready  = {NS{pready_en}};
  assign pslverr = {NS{err_en && paddr == err_addr}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop expectations whenever the DUT completes a handshake.
  always @(negedge aclk) begin
    if (areset_n) begin
      if (|psel) sel_cnt++;
      if (|psel && penable) pen_cnt++;
      if (|psel && penable && pready_en) begin
        if (apb_q.size() == 0) check("apb_unexpected", 64'(paddr), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          apb_t e;
          e = apb_q.pop_front();
          check("apb_addr", 64'(paddr), 64'(e.addr));
          check("apb_write", 64'(pwrite), 64'(e.wr));
          check("apb_psel", 64'(psel), 64'(NS'(1) << e.slv));
          if (e.wr) check("apb_wdata", 64'(pwdata), 64'(e.wd));
        end
      end
      if (rvalid && rready) begin
        r_times.push_back(cyc);
        if (r_q.size() == 0) check("r_unexpected", 64'(rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          r_t e;
          e = r_q.pop_front();
          check("r_id", 64'(rid), 64'(e.id));
          check("r_data", 64'(rdata), 64'(e.d));
          check("r_resp", 64'(rresp), 64'(e.resp));
          check("r_last", 64'(rlast), 64'(e.last));
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) check("b_unexpected", 64'(bresp), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          b_t e;
          e = b_q.pop_front();
          check("b_id", 64'(bid), 64'(e.id));
          check("b_resp", 64'(bresp), 64'(e.resp));
        end
      end
      if (arvalid && arready) begin
        if (ord_q.size() == 0) check("order_unexpected_ar", 64'd0, 64'd9);
        else check("service_order", 64'd0, 64'(ord_q.pop_front()));
      end
      if (awvalid && awready) begin
        if (ord_q.size() == 0) check("order_unexpected_aw", 64'd1, 64'd9);
        else check("service_order", 64'd1, 64'(ord_q.pop_front()));
      end
    end
  end

  function automatic apb_t mk_apb(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input int s);
    apb_t e;
    e.addr = a; e.wr = w; e.wd = d; e.slv = s;
    return e;
  endfunction

  function automatic r_t mk_r(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
    r_t e;
    e.id = id; e.d = d; e.resp = resp; e.last = last;
    return e;
  endfunction

  function automatic b_t mk_b(input logic [IW-1:0] id, input logic [1:0] resp);
    b_t e;
    e.id = id; e.resp = resp;
    return e;
  endfunction

  task automatic do_reset();
    @(posedge aclk); #1;
    areset_n = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset_n = 1'b1;
  endtask

  task automatic do_ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    @(posedge aclk); #1;
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge aclk);
      if (arready) begin @(posedge aclk); #1 arvalid = 1'b0; done = 1; end
    end
    if (!done) begin arvalid = 1'b0; check("ar_handshake_timeout", 64'd0, 64'd1); end
  endtask

  task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    @(posedge aclk); #1;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge aclk);
      if (awready) begin @(posedge aclk); #1 awvalid = 1'b0; done = 1; end
    end
    if (!done) begin awvalid = 1'b0; check("aw_handshake_timeout", 64'd0, 64'd1); end
  endtask

  // Beat b carries d0 + b; every beat must be accepted within the budget.
  task automatic do_w(input logic [IW-1:0] id, input logic [DW-1:0] d0, input int len);
    for (int b = 0; b <= len; b++) begin
      bit done = 0;
      @(posedge aclk); #1;
      wid = id; wdata = d0 + DW'(b); wlast = (b == len); wvalid = 1'b1;
      for (int t = 0; t < 300 && !done; t++) begin
        @(negedge aclk);
        if (wready) begin @(posedge aclk); #1 wvalid = 1'b0; done = 1; end
      end
      if (!done) begin wvalid = 1'b0; check("w_accept_timeout", 64'(b), 64'hFF); end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 400; t++) begin
      @(negedge aclk);
      if (apb_q.size() == 0 && r_q.size() == 0 && b_q.size() == 0 && ord_q.size() == 0 &&
          !bvalid && !rvalid && !(|psel)) break;
    end
    check(name, 64'(apb_q.size() + r_q.size() + b_q.size() + ord_q.size()), 64'd0);
  endtask

  initial begin : stim
    areset_n = 1'b0; pready_en = 1'b1; err_en = 1'b0; err_addr = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '1; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_outputs", 64'({awready, wready, bvalid, arready, rvalid, rlast, penable, pwrite, psel,
                                bresp, rresp, bid, rid}), 64'd0);
    check("reset_data", 64'({paddr, rdata}) | 64'(pwdata), 64'd0);
    #1 areset_n = 1'b1;
    repeat (2) @(negedge aclk);
    check("idle_outputs", 64'({awready, wready, bvalid, arready, rvalid, penable, psel}), 64'd0);

    // INCR read, 4 beats from slave 0.
    ord_q.push_back(0);
    for (int b = 0; b < 4; b++) begin
      apb_q.push_back(mk_apb(32'h1000 + 32'(4*b), 1'b0, '0, 0));
      r_q.push_back(mk_r(4'h5, 32'h0000_1000 + 32'(4*b), 2'b00, b == 3));
    end
    r_times.delete();
    do_ar(4'h5, 32'h0000_1000, 4'd3, 3'd2, 2'b01);
    wait_drain("incr_read_drain");
    if (r_times.size() >= 2) check("rd_beat_spacing", 64'(r_times[1] - r_times[0]), 64'd3);
    else check("rd_beat_count", 64'(r_times.size()), 64'd4);

    // WRAP write, 4 beats to slave 1.
    ord_q.push_back(1);
    apb_q.push_back(mk_apb(32'h2038, 1'b1, 32'hA000_0000, 1));
    apb_q.push_back(mk_apb(32'h203C, 1'b1, 32'hA000_0001, 1));
    apb_q.push_back(mk_apb(32'h2030, 1'b1, 32'hA000_0002, 1));
    apb_q.push_back(mk_apb(32'h2034, 1'b1, 32'hA000_0003, 1));
    b_q.push_back(mk_b(4'h3, 2'b00));
    fork
      do_aw(4'h3, 32'h0000_2038, 4'd3, 3'd2, 2'b10);
      do_w(4'h3, 32'hA000_0000, 3);
    join
    wait_drain("wrap_write_drain");

    // Unmapped write: both beats consumed, no PSEL, DECERR.
    ord_q.push_back(1);
    b_q.push_back(mk_b(4'h7, 2'b11));
    sel_cnt = 0;
    fork
      do_aw(4'h7, 32'h0000_8000, 4'd1, 3'd2, 2'b01);
      do_w(4'h7, 32'hB000_0000, 1);
    join
    wait_drain("unmapped_write_drain");
    check("unmapped_no_psel", 64'(sel_cnt), 64'd0);

    // Read of 3 beats from slave 2 with PSLVERR on the middle beat.
    err_en = 1'b1; err_addr = 32'h0000_3004;
    ord_q.push_back(0);
    apb_q.push_back(mk_apb(32'h3000, 1'b0, '0, 2));
    apb_q.push_back(mk_apb(32'h3004, 1'b0, '0, 2));
    apb_q.push_back(mk_apb(32'h3008, 1'b0, '0, 2));
    r_q.push_back(mk_r(4'h2, 32'h2000_3000, 2'b00, 1'b0));
    r_q.push_back(mk_r(4'h2, 32'h2000_3004, 2'b10, 1'b0));
    r_q.push_back(mk_r(4'h2, 32'h2000_3008, 2'b00, 1'b1));
    do_ar(4'h2, 32'h0000_3000, 4'd2, 3'd2, 2'b01);
    wait_drain("slverr_read_drain");
    err_en = 1'b0;

    // Simultaneous AW/AR twice after reset: read, write, read, write.
    do_reset();
    ord_q.push_back(0); ord_q.push_back(1);
    apb_q.push_back(mk_apb(32'h1010, 1'b0, '0, 0));
    apb_q.push_back(mk_apb(32'h2000, 1'b1, 32'h1111_0000, 1));
    r_q.push_back(mk_r(4'h1, 32'h0000_1010, 2'b00, 1'b1));
    b_q.push_back(mk_b(4'h9, 2'b00));
    fork
      do_ar(4'h1, 32'h0000_1010, 4'd0, 3'd2, 2'b01);
      do_aw(4'h9, 32'h0000_2000, 4'd0, 3'd2, 2'b01);
      do_w(4'h9, 32'h1111_0000, 0);
    join
    wait_drain("tie1_drain");
    ord_q.push_back(0); ord_q.push_back(1);
    apb_q.push_back(mk_apb(32'h4000, 1'b0, '0, 3));
    apb_q.push_back(mk_apb(32'h4004, 1'b1, 32'h2222_0000, 3));
    r_q.push_back(mk_r(4'h4, 32'h3000_4000, 2'b00, 1'b1));
    b_q.push_back(mk_b(4'hA, 2'b00));
    fork
      do_ar(4'h4, 32'h0000_4000, 4'd0, 3'd2, 2'b00);
      do_aw(4'hA, 32'h0000_4004, 4'd0, 3'd2, 2'b00);
      do_w(4'hA, 32'h2222_0000, 0);
    join
    wait_drain("tie2_drain");

`ifdef AMBA3_AXI2APB_TIMEOUT_EN
    // PREADY stuck low: ACCESS ends after 8 cycles with SLVERR and zero data.
    pready_en = 1'b0;
    pen_cnt = 0;
    ord_q.push_back(0);
    r_q.push_back(mk_r(4'h6, 32'h0, 2'b10, 1'b1));
    do_ar(4'h6, 32'h0000_1000, 4'd0, 3'd2, 2'b01);
    wait_drain("timeout_drain");
    check("timeout_access_cycles", 64'(pen_cnt), 64'd8);
    pready_en = 1'b1;
`endif

    // Reset mid-burst drops the transaction and clears the APB/AXI outputs at once.
    ord_q.push_back(0);
    do_ar(4'h8, 32'h0000_1000, 4'd7, 3'd2, 2'b01);
    @(negedge aclk);
    areset_n = 1'b0;
    @(negedge aclk);
    check("midreset_outputs", 64'({psel, penable, rvalid, bvalid, wready, arready, awready}), 64'd0);
    r_q.delete(); apb_q.delete();
    #1 areset_n = 1'b1;
    repeat (3) @(negedge aclk);
    check("post_reset_idle", 64'({psel, penable, rvalid}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amba3_axi2apb_bridge.md
# amba3_axi2apb_bridge

Synthesisable AXI3-slave to APB3-master bridge fanning out to `NUM_SLAVES` decoded APB slaves. It accepts one AXI transaction at a time and splits FIXED, INCR and WRAP bursts into per-beat APB transfers. Per-beat APB responses are mapped onto AXI responses. It sits between the AXI interconnect and the low-speed register peripherals, and is the RTL counterpart of the AMBA 3 verification components in `pkg_amba3`.

## Interface

**Parameters**
- `ADDR_WIDTH`, 32: AXI and APB address width.
- `DATA_WIDTH`, 32: data width; 32 or 64.
- `ID_WIDTH`, 4: AXI ID width.
- `NUM_SLAVES`, 4: number of APB slaves, 1..16.
- `SLAVE_BASE`, `{NUM_SLAVES{ADDR_WIDTH'0}}`: packed array of base addresses, one per slave.
- `SLAVE_MASK`, `{NUM_SLAVES{ADDR_WIDTH'hFFFF_F000}}`: packed array of compare masks; slave `i` hits when `(addr & SLAVE_MASK[i]) == SLAVE_BASE[i]`.
- `TIMEOUT_CYCLES`, 256: PREADY timeout. Used only when the timeout macro is defined.

**Ports**
- `aclk` in 1: clock.
- `areset_n` in 1: synchronous, active-low reset.
- `awid`/`awaddr`/`awlen[3:0]`/`awsize[2:0]`/`awburst[1:0]` in; `awvalid` in 1; `awready` out 1: AXI write address channel.
- `wid`/`wdata`/`wstrb`/`wlast` in; `wvalid` in 1; `wready` out 1: write data. `wstrb` is ignored; APB3 has no strobes.
- `bid` out ID; `bresp` out 2; `bvalid` out 1; `bready` in 1: write response.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst` in; `arvalid` in 1; `arready` out 1: read address.
- `rid` out ID; `rdata` out DATA; `rresp` out 2; `rlast` out 1; `rvalid` out 1; `rready` in 1: read data.
- `paddr` out ADDR; `pwrite` out 1; `pwdata` out DATA; `penable` out 1; `psel` out NUM_SLAVES: APB master request.
- `prdata` in NUM_SLAVES*DATA; `pready` in NUM_SLAVES; `pslverr` in NUM_SLAVES: per-slave APB returns, selected by the latched decode index.

## Operation

**FSM states:** IDLE, WDATA, SETUP, ACCESS, RBEAT, BRESP.

**IDLE**
- Transaction selection:
  - If only one of `awvalid`/`arvalid` is asserted, that channel is taken.
  - If both are asserted, selection alternates. After reset, read wins first.
- On selection:
  - Pulse `awready` or `arready` for one cycle.
  - Latch id, address, len, size and burst.
  - Clear the beat counter and set the accumulated write response to OKAY.
- Next state: WDATA for writes, SETUP for reads.

**WDATA**
- `wready` is high.
- On `wvalid`, capture `wdata`, then go to SETUP.

**SETUP**
- Decode the current address. The lowest-index hit wins.
- On a hit: assert `psel[idx]`, `penable=0` and drive `paddr`/`pwrite`/`pwdata`.
- On a decode miss, or when `size > log2(DATA_WIDTH/8)`:
  - No PSEL is issued.
  - The beat response is DECERR (miss) or SLVERR (oversize).
  - Go directly to the beat-completion step.
- Otherwise, go to ACCESS.

**ACCESS**
- `penable=1`; wait for `pready[idx]`.
- Beat response is SLVERR if `pslverr[idx]`, else OKAY.
- For reads, capture `prdata[idx]`.

**Beat completion**
- Read: go to RBEAT.
- Write:
  - Accumulate the response by max severity (DECERR > SLVERR > OKAY).
  - If `wlast` disagrees with the beat count, the accumulated response becomes SLVERR.
  - Go to BRESP on the last beat, else WDATA.

**RBEAT**
- Hold `rvalid` and the R payload until `rready`.
- `rlast` is high on beat `len`.
- Next state: SETUP, or IDLE after the last beat.

**BRESP**
- Hold `bvalid` until `bready`, then go to IDLE.

**Address update** after each beat, with `bytes = 1 << size`:
- FIXED: address unchanged.
- INCR: `addr + bytes`.
- WRAP:
  - Container = `(len+1)*bytes`; len must be 1, 3, 7 or 15.
  - The lower `log2(container)` bits wrap; upper bits are kept.
  - Any other len is treated as INCR.
- Burst encoding 2'b11 is treated as INCR.

## Timing

- **Reset values:** all outputs are 0, the FSM is in IDLE, and arbitration priority is set to read.
- **Reset mid-transaction:** the transaction is dropped. PSEL/PENABLE and VALIDs fall on the same edge.
- **Latency:**
  - Address handshake to PSEL: 1 cycle for reads, ≥2 cycles for writes.
  - Zero-wait-state APB beat: SETUP + ACCESS, 2 cycles.
  - `rvalid` rises 1 cycle after the `pready` cycle.
  - Sustained read throughput: 3 cycles per beat with `rready` tied high.
- **Handshake rule:** VALID signals never depend combinationally on READY. READY outputs are registered state decodes.
- **Error beats:** DECERR/SLVERR-without-access beats still consume W data and emit R beats (`rdata=0`). Bursts are never truncated.

## Configuration

- `AMBA3_AXI2APB_TIMEOUT_EN` defined:
  - A counter runs in ACCESS.
  - If `pready` stays low for `TIMEOUT_CYCLES` cycles, the beat ends with SLVERR and PSEL is dropped.
- Undefined: the counter is not built, and ACCESS waits indefinitely.

## Structure

- Add to `pkg_amba3`:
  - bridge state enum `axi2apb_state_t`;
  - function `next_burst_addr(addr, len, size, burst)`;
  - response merge function `resp_max`.
- These reuse the existing `burst_type_t` and `resp_type_t`.
- One sub-module: `amba3_apb_decoder`, a combinational address-to-index-plus-hit decoder over `SLAVE_BASE`/`SLAVE_MASK`.

## Test plan

- INCR read, `araddr=0x1000`, len 3, size 2, slave 0 zero-wait → 4 R beats at 0x1000/04/08/0C, `rlast` on beat 4, all OKAY.
- WRAP write, `awaddr=0x2038`, len 3, size 2 → APB addresses 0x2038, 0x203C, 0x2030, 0x2034; single B with OKAY.
- Write to an unmapped address, len 1 → no PSEL, both W beats accepted, `bresp=DECERR`.
- Read with `pslverr` on beat 2 of 3 → `rresp` sequence OKAY, SLVERR, OKAY.
- `awvalid` and `arvalid` asserted together twice after reset → service order: read, write, read, write.
- With `AMBA3_AXI2APB_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, `pready` held low → PSEL drops after 8 ACCESS cycles, `rresp=SLVERR`.
